// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions and the transmitter state encoding.
package uart_tx_pkg;

    localparam logic [31:0] OFS_TXDATA  = 32'h0;
    localparam logic [31:0] OFS_STATUS  = 32'h4;
    localparam logic [31:0] OFS_BAUDDIV = 32'h8;

    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_EMPTY_BIT = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;
    localparam int ST_CNT_MSB   = 7;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Divider values below the minimum would make a bit shorter than the
    // reload/compare scheme can represent, so they are raised to DIV_MIN.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-bus view of the UART: load/store strobes, address, write data,
// and the combinational select/read-data returned by the peripheral.
interface mmio_uart_tx_if;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sel;
    logic [31:0] rdata;

    modport master (
        output we,
        output re,
        output addr,
        output wdata,
        input  sel,
        input  rdata
    );

    modport slave (
        input  we,
        input  re,
        input  addr,
        input  wdata,
        output sel,
        output rdata
    );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Small synchronous FIFO with wrap-around pointers and a combinational head.
// A push while full is accepted only if a pop frees the slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_q - rd_q;
    assign empty   = (wr_q == rd_q);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // The head is read combinationally so the consumer can load it on the pop edge.
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: TXDATA/STATUS/BAUDDIV registers with
// zero-latency read decode, a byte FIFO, and a bit-timing state machine.
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h810,
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic                 clk,
    input  logic                 reset1,
    mmio_uart_tx_if.slave        bus,
    output logic                 tx,
    output logic                 tx_idle
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] S_IDLE  = TX_IDLE;
    localparam logic [1:0] S_START = TX_START;
    localparam logic [1:0] S_DATA  = TX_DATA;
    localparam logic [1:0] S_STOP  = TX_STOP;

    logic        hit_tx, hit_st, hit_bd;
    logic        push_req;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0] count_ext;
    logic [31:0] status_w;
    logic        busy;

    logic [1:0]  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;
    logic [15:0] reload;

    logic        unused_wdata;
    assign unused_wdata = ^bus.wdata[31:16];

    // Only the three exact word addresses decode; misaligned offsets miss.
    assign hit_tx  = (bus.addr == BASE_ADDR + OFS_TXDATA);
    assign hit_st  = (bus.addr == BASE_ADDR + OFS_STATUS);
    assign hit_bd  = (bus.addr == BASE_ADDR + OFS_BAUDDIV);
    assign bus.sel = hit_tx | hit_st | hit_bd;

    assign push_req = bus.we & hit_tx;
    assign busy     = (state_q != S_IDLE);
    assign count_ext = 32'(fifo_count);
    assign reload   = div_q - 16'd1;

    always_comb begin
        status_w                        = '0;
        status_w[ST_BUSY_BIT]           = busy;
        status_w[ST_FULL_BIT]           = fifo_full;
        status_w[ST_EMPTY_BIT]          = fifo_empty;
        status_w[ST_OVF_BIT]            = ovf_q;
        status_w[ST_CNT_MSB:ST_CNT_LSB] = count_ext[3:0];
    end

    always_comb begin
        bus.rdata = '0;
        if (hit_st)      bus.rdata = status_w;
        else if (hit_bd) bus.rdata = {16'h0000, div_q};
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset1),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (bus.wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        div_d = div_q;
        if (bus.we && hit_bd) div_d = clamp_div(bus.wdata[15:0]);
    end

    // A dropped push outranks the read-to-clear on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (bus.re && hit_st) ovf_d = 1'b0;
        if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_d     = fifo_dout;
                    baud_d   = reload;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (baud_q == 16'd0) begin
                    baud_d  = reload;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_q == 16'd0) begin
                    sh_d   = {1'b0, sh_q[7:1]};
                    baud_d = reload;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_STOP: begin
                if (baud_q == 16'd0) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sh_d     = fifo_dout;
                        baud_d   = reload;
                        state_d  = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset1) begin
        if (!reset1) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            div_q   <= DIV_RESET;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = sh_q[0];
            default: tx = 1'b1;
        endcase
    end

    assign tx_idle = fifo_empty & (state_q == S_IDLE);

endmodule
